ip_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the internal MSX-50BUS-style device bus, which serves the PPI clone and sibling I/O and memory devices. It grants one transaction at a time to either master 0 (the CPU bridge) or master 1 (an auxiliary loader or debug master), using round-robin priority. It drives single-cycle read/write strobes, waits for `bus_read_ready` with a bounded timeout, and returns data plus a one-cycle acknowledge to the granted master.

---
 rtl/ip_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ip_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ip_bus_arbiter.sv
// ip_bus_arbiter
//   Two-master round-robin arbiter and sequencer for the internal device bus.
//   One transaction is in flight at a time. The sequence is IDLE -> ISSUE (strobe)
//   -> [WAIT_READ] -> DONE (ack). Reads give up after TIMEOUT_CYCLES wait cycles
//   and return FFh with a bus_timeout pulse.
//
// Ports
//   clk, n_reset            : clock (rising edge), async active-low reset
//   mX_req                  : level request, held until mX_ack
//   mX_address/write_data   : transaction address / write data
//   mX_write, mX_io         : 1 = write / 1 = I/O space
//   mX_ack, mX_read_data    : one-cycle completion pulse + read data (00h otherwise)
//   bus_timeout             : pulses with the ack of an abandoned read
//   bus_address/write_data  : latched request, held between transactions
//   bus_read/write/io/memory: one-cycle strobes and space qualifiers
//   bus_read_ready/data     : OR-ed device read response
//
// All outputs come straight from flops. The comb block computes the next value
// of every output register together with the next state.
module ip_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic [15:0] m0_address,
    input  logic [15:0] m1_address,
    input  logic [7:0]  m0_write_data,
    input  logic [7:0]  m1_write_data,
    input  logic        m0_write,
    input  logic        m1_write,
    input  logic        m0_io,
    input  logic        m1_io,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [7:0]  m0_read_data,
    output logic [7:0]  m1_read_data,
    output logic        bus_timeout,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_write_data,
    output logic        bus_read,
    output logic        bus_write,
    output logic        bus_io,
    output logic        bus_memory,
    input  logic        bus_read_ready,
    input  logic [7:0]  bus_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ, DONE} state_t;

    typedef struct packed {
        logic [15:0] address;
        logic [7:0]  write_data;
        logic        write;
        logic        io;
    } bus_req_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic             io_q, io_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             rd_q, rd_d, wr_q, wr_d, bio_q, bio_d, bmem_q, bmem_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0][7:0]  rdata_q, rdata_d;
    logic             to_q, to_d;

    bus_req_t m0_r, m1_r, req_sel;
    logic     sel;

    assign m0_r    = {m0_address, m0_write_data, m0_write, m0_io};
    assign m1_r    = {m1_address, m1_write_data, m1_write, m1_io};
    // On a tie the master that did not win last time gets the bus.
    assign sel     = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    assign req_sel = sel ? m1_r : m0_r;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        io_d         = io_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        bio_d        = 1'b0;
        bmem_d       = 1'b0;
        ack_d        = '0;
        rdata_d      = '0;
        to_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    addr_d       = req_sel.address;
                    wdata_d      = req_sel.write_data;
                    write_d      = req_sel.write;
                    io_d         = req_sel.io;
                    // Strobes are loaded here so they are high during ISSUE.
                    wr_d         = req_sel.write;
                    rd_d         = ~req_sel.write;
                    bio_d        = req_sel.io;
                    bmem_d       = ~req_sel.io;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (write_q) begin
                    ack_d[grant_q] = 1'b1;
                    state_d        = DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT_READ;
                end
            end
            WAIT_READ: begin
                // A ready on the final count wins over the timeout.
                if (bus_read_ready) begin
                    ack_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = bus_read_data;
                    state_d          = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = 8'hFF;
                    to_d             = 1'b1;
                    state_d          = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            io_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            bio_q        <= 1'b0;
            bmem_q       <= 1'b0;
            ack_q        <= '0;
            rdata_q      <= '0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            io_q         <= io_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            bio_q        <= bio_d;
            bmem_q       <= bmem_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            to_q         <= to_d;
        end
    end

    assign m0_ack         = ack_q[0];
    assign m1_ack         = ack_q[1];
    assign m0_read_data   = rdata_q[0];
    assign m1_read_data   = rdata_q[1];
    assign bus_timeout    = to_q;
    assign bus_address    = addr_q;
    assign bus_write_data = wdata_q;
    assign bus_read       = rd_q;
    assign bus_write      = wr_q;
    assign bus_io         = bio_q;
    assign bus_memory     = bmem_q;

endmodule

// File: tb/tb_ip_bus_arbiter.sv
// tb_ip_bus_arbiter
//   Directed bench for ip_bus_arbiter (TIMEOUT_CYCLES = 15). Inputs are driven
//   1 time unit after the rising edge, and outputs are checked at that same point.
//   "Edge En" below means the n-th rising edge after the edge that samples the request (E0).
module tb_ip_bus_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        m0_req, m1_req;
    logic [15:0] m0_address, m1_address;
    logic [7:0]  m0_write_data, m1_write_data;
    logic        m0_write, m1_write, m0_io, m1_io;
    logic        m0_ack, m1_ack;
    logic [7:0]  m0_read_data, m1_read_data;
    logic        bus_timeout;
    logic [15:0] bus_address;
    logic [7:0]  bus_write_data;
    logic        bus_read, bus_write, bus_io, bus_memory;
    logic        bus_read_ready;
    logic [7:0]  bus_read_data;

    ip_bus_arbiter #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .n_reset(n_reset),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_address(m0_address), .m1_address(m1_address),
        .m0_write_data(m0_write_data), .m1_write_data(m1_write_data),
        .m0_write(m0_write), .m1_write(m1_write),
        .m0_io(m0_io), .m1_io(m1_io),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_read_data(m0_read_data), .m1_read_data(m1_read_data),
        .bus_timeout(bus_timeout),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_io(bus_io), .bus_memory(bus_memory),
        .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic r, input logic [15:0] a, input logic [7:0] d,
                          input logic w, input logic io);
        m0_req = r; m0_address = a; m0_write_data = d; m0_write = w; m0_io = io;
    endtask

    task automatic set_m1(input logic r, input logic [15:0] a, input logic [7:0] d,
                          input logic w, input logic io);
        m1_req = r; m1_address = a; m1_write_data = d; m1_write = w; m1_io = io;
    endtask

    function automatic logic [63:0] all_outs();
        return {m0_ack, m1_ack, m0_read_data, m1_read_data, bus_timeout,
                bus_address, bus_write_data, bus_read, bus_write, bus_io, bus_memory};
    endfunction

    initial begin
        n_reset = 1'b0;
        set_m0(0, 16'h0, 8'h0, 0, 0);
        set_m1(0, 16'h0, 8'h0, 0, 0);
        bus_read_ready = 1'b0;
        bus_read_data  = 8'h00;

        // Reset state.
        tick(); tick();
        chk("reset_outputs", all_outs(), 64'h0);
        n_reset = 1'b1;
        tick();

        // m0 I/O write A9h -> 00A8h.
        set_m0(1, 16'h00A8, 8'hA9, 1, 1);
        tick();                                   // E0
        chk("wr_strobe", {bus_write, bus_read, bus_io, bus_memory}, 4'b1010);
        chk("wr_addr", bus_address, 16'h00A8);
        chk("wr_data", bus_write_data, 8'hA9);
        chk("wr_no_early_ack", m0_ack, 1'b0);
        tick();                                   // E1: ack in E1..E2
        chk("wr_strobe_off", {bus_write, bus_read, bus_io, bus_memory}, 4'b0000);
        chk("wr_ack", {m0_ack, m1_ack}, 2'b10);
        chk("wr_rdata", m0_read_data, 8'h00);
        set_m0(0, 16'h00A8, 8'hA9, 1, 1);
        tick();
        chk("wr_ack_off", m0_ack, 1'b0);
        chk("wr_addr_hold", bus_address, 16'h00A8);

        // m1 I/O read 00A9h, device ready one cycle after the strobe.
        set_m1(1, 16'h00A9, 8'h00, 0, 1);
        tick();                                   // E0
        chk("rd_strobe", {bus_write, bus_read, bus_io, bus_memory}, 4'b0110);
        chk("rd_addr", bus_address, 16'h00A9);
        tick();                                   // E1: now WAIT_READ
        chk("rd_no_early_ack", {m0_ack, m1_ack, bus_read}, 3'b000);
        bus_read_ready = 1'b1; bus_read_data = 8'h5A;
        tick();                                   // E2
        chk("rd_ack", {m0_ack, m1_ack}, 2'b01);
        chk("rd_data", m1_read_data, 8'h5A);
        chk("rd_other_data", m0_read_data, 8'h00);
        chk("rd_no_timeout", bus_timeout, 1'b0);
        bus_read_ready = 1'b0; bus_read_data = 8'h00;
        set_m1(0, 16'h00A9, 8'h00, 0, 1);
        tick();
        chk("rd_ack_off", {m1_ack, m1_read_data}, 9'h0);

        // Both masters hold writes; m1 was last, so m0, m1, m0, m1.
        set_m0(1, 16'h0010, 8'h11, 1, 0);
        set_m1(1, 16'h0020, 8'h22, 1, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_strobe", {bus_write, bus_read}, 2'b10);
            chk("rr_addr", bus_address, (k % 2 == 1) ? 16'h0020 : 16'h0010);
            chk("rr_wdata", bus_write_data, (k % 2 == 1) ? 8'h22 : 8'h11);
            tick();
            chk("rr_ack", {m0_ack, m1_ack}, (k % 2 == 1) ? 2'b01 : 2'b10);
            chk("rr_strobe_off", {bus_write, bus_read}, 2'b00);
            if (k == 3) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
            tick();
        end
        chk("rr_quiet", {m0_ack, m1_ack, bus_write, bus_read}, 4'b0000);

        // m0 read, device never ready: ack in cycle E16..E17 with FFh + timeout.
        set_m0(1, 16'h0099, 8'h00, 0, 1);
        tick();                                   // E0
        chk("to_strobe", {bus_read, bus_io}, 2'b11);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (m0_ack) break;
        end
        chk("to_latency", n, 16);
        chk("to_data", m0_read_data, 8'hFF);
        chk("to_flag", bus_timeout, 1'b1);
        chk("to_other_ack", m1_ack, 1'b0);
        set_m0(0, 16'h0099, 8'h00, 0, 1);
        tick();
        chk("to_flag_off", {bus_timeout, m0_ack}, 2'b00);

        // Same read, ready lands exactly on the last count (sampled at E16).
        set_m0(1, 16'h0099, 8'h00, 0, 1);
        tick();                                   // E0
        repeat (15) tick();                       // E15
        chk("rdy14_no_early_ack", m0_ack, 1'b0);
        bus_read_ready = 1'b1; bus_read_data = 8'h3C;
        tick();                                   // E16
        chk("rdy14_ack", m0_ack, 1'b1);
        chk("rdy14_data", m0_read_data, 8'h3C);
        chk("rdy14_no_timeout", bus_timeout, 1'b0);
        bus_read_ready = 1'b0; bus_read_data = 8'h00;
        set_m0(0, 16'h0099, 8'h00, 0, 1);
        tick();

        // Reset while m0 read sits in WAIT_READ (last_grant is m0 here).
        set_m0(1, 16'h0099, 8'h00, 0, 1);
        tick(); tick(); tick();                   // E2, counting
        chk("mid_addr_before", bus_address, 16'h0099);
        n_reset = 1'b0;
        #1;
        chk("mid_rst_async", all_outs(), 64'h0);
        set_m0(0, 16'h0099, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_ack", {m0_ack, m1_ack}, 2'b00);
        end
        n_reset = 1'b1;

        // Tie after reset goes to m0 (memory write), then m1 read completes.
        set_m0(1, 16'h0030, 8'h33, 1, 0);
        set_m1(1, 16'h00A9, 8'h00, 0, 1);
        tick();                                   // E0
        chk("post_tie_strobe", {bus_write, bus_read, bus_io, bus_memory}, 4'b1001);
        chk("post_tie_addr", bus_address, 16'h0030);
        chk("post_tie_wdata", bus_write_data, 8'h33);
        tick();
        chk("post_m0_ack", {m0_ack, m1_ack}, 2'b10);
        set_m0(0, 16'h0030, 8'h33, 1, 0);
        tick();                                   // IDLE
        tick();                                   // m1 granted
        chk("post_m1_strobe", {bus_write, bus_read, bus_io, bus_memory}, 4'b0110);
        chk("post_m1_addr", bus_address, 16'h00A9);
        tick();
        bus_read_ready = 1'b1; bus_read_data = 8'hC3;
        tick();
        chk("post_m1_ack", {m0_ack, m1_ack}, 2'b01);
        chk("post_m1_data", m1_read_data, 8'hC3);
        chk("post_m1_no_timeout", bus_timeout, 1'b0);
        bus_read_ready = 1'b0; bus_read_data = 8'h00;
        set_m1(0, 16'h00A9, 8'h00, 0, 1);
        tick();
        chk("post_m1_ack_off", {m1_ack, m1_read_data}, 9'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
